imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter PC_W, default XLEN, width of the PC tag carried with each instruction.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port flush  in  1  synchronous pipeline flush.
REQ-006 Port in_valid  in  1  upstream instruction valid.
REQ-007 Port in_ready  out  1  block can accept an instruction this cycle.
REQ-008 Port in_instr  in  32  raw RV32 instruction word.
REQ-009 Port in_pc  in  PC_W  PC tag, passed through unchanged.
REQ-010 Port out_valid  out  1  decoded entry valid.
REQ-011 Port out_ready  in  1  downstream accepts the entry.
REQ-012 Port out_imm  out  XLEN  extended immediate.
REQ-013 Port out_imm_src  out  3  immediate format code.
REQ-014 Port out_illegal  out  1  opcode not recognised.
REQ-015 Port out_pc  out  PC_W  PC tag of the entry.

Function
REQ-016 Format codes: I=000, S=001, B=010, J=011, U=100, Z=101, NONE=111.
REQ-017 Opcode map: 0000011/0010011/1100111 -> I; 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110111/0010111 -> U; 0110011 -> NONE, illegal=0; any other opcode -> NONE, illegal=1.
REQ-018 Extension: I, S, B, J sign-extended from instr[31] to XLEN; U = {instr[31:12], 12'b0} sign-extended to XLEN; Z = instr[19:15] zero-extended; NONE -> imm=0; no X values on any output.
REQ-019 Latency: an instruction accepted (in_valid & in_ready) in cycle N appears on the outputs with out_valid=1 in cycle N+1.
REQ-020 Storage: output register plus one skid register; total capacity 2 entries; strict FIFO order.
REQ-021 in_ready is a registered signal, equal to 1 exactly when the skid register is empty.
REQ-022 Output entry retires when out_valid & out_ready; the skid entry, if present, moves to the output register in the same edge.
REQ-023 Simultaneous accept and retire with skid empty: new entry loads the output register directly; throughput 1 per cycle.
REQ-024 Outputs are held stable while out_valid=1 and out_ready=0.
REQ-025 flush=1: both entries invalidated on that edge; any instruction presented that cycle is dropped; flush has priority over accept and retire.
REQ-026 Payload registers of invalid entries may hold stale data, but out_imm/out_imm_src/out_illegal/out_pc are qualified only by out_valid.

Reset
REQ-027 rst_n low: out_valid=0, in_ready=1, out_imm=0, out_imm_src=111, out_illegal=0, out_pc=0, skid empty, immediately and asynchronously.
REQ-028 Reset asserted mid-transfer discards all held entries; the first accept after release behaves as from empty.

Configuration
REQ-029 Macro IMM_GEN_ZICSR_EN: when defined, opcode 1110011 decodes as Z, illegal=0.
REQ-030 Without IMM_GEN_ZICSR_EN, opcode 1110011 decodes as NONE, imm=0, illegal=1; code Z never produced.

Structure
REQ-031 Format-code constants (IMM_I..IMM_NONE) and RV32 opcode constants reside in shared package riscv_pkg.
REQ-032 Combinational opcode-to-format and extension logic is a sub-module imm_extend (instr in; imm, imm_src, illegal out), instantiated once at the input side.

Verification
REQ-033 Reset: hold rst_n=0 3 cycles -> out_valid=0, in_ready=1, out_imm_src=111; release -> unchanged until first accept.
REQ-034 addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, src=000; lui 0x123450B7 -> imm=0x12345000, src=100.
REQ-035 sw x1,-4(x2) (0xFE112E23) -> imm=0xFFFFFFFC, src=001; beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, src=010.
REQ-036 Back-pressure: out_ready=0, present three instrs back-to-back -> first two accepted, in_ready=0 from the cycle after the second accept; raise out_ready -> all three emitted in order, none lost or duplicated.
REQ-037 flush=1 with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed and presented instrs never appear.
REQ-038 0x0000007F -> out_illegal=1, imm=0, src=111; 0x00000073 -> src=101 with IMM_GEN_ZICSR_EN, illegal=1 without.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 opcode constants, immediate format codes and the entry-occupancy state type.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_NONE = 3'b111
  } imm_src_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_e;

endpackage

// File: rtl/imm_extend.sv
// Combinational opcode-to-format decode and immediate extension for RV32 words.
// Optional CSR immediate decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_extend
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_src,
  output logic            illegal
);

  imm_src_e    src;
  logic [31:0] imm32;

  always_comb begin
    src     = IMM_NONE;
    illegal = 1'b0;
    unique case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: src = IMM_I;
      OPC_STORE:                      src = IMM_S;
      OPC_BRANCH:                     src = IMM_B;
      OPC_JAL:                        src = IMM_J;
      OPC_LUI, OPC_AUIPC:             src = IMM_U;
      OPC_OP:                         src = IMM_NONE;
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM:                     src = IMM_Z;
`else
      OPC_SYSTEM:                     illegal = 1'b1;
`endif
      default:                        illegal = 1'b1;
    endcase
  end

  // Every format is built as a 32-bit value whose bit 31 is the correct
  // sign for widening; Z has bit 31 clear so the same widening zero-extends.
  always_comb begin
    imm32 = '0;
    unique case (src)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'h000};
      IMM_Z:   imm32 = {27'd0, instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign imm_src = src;

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-entry (output + skid) pipelined immediate generator with valid/ready on both sides.
// IMM_GEN_ZICSR_EN enables Z-format decode of SYSTEM opcodes in imm_extend.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_src,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_src;
  logic            dec_ill;

  imm_extend #(.XLEN(XLEN)) u_ext (
    .instr   (in_instr),
    .imm     (dec_imm),
    .imm_src (dec_src),
    .illegal (dec_ill)
  );

  occ_e state, state_n;
  logic in_ready_q;
  logic accept, retire;
  logic load_out_new, load_out_skid, load_skid;

  logic [XLEN-1:0] out_imm_q, skid_imm_q;
  logic [2:0]      out_src_q, skid_src_q;
  logic            out_ill_q, skid_ill_q;
  logic [PC_W-1:0] out_pc_q,  skid_pc_q;

  assign out_valid = (state != OCC_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign retire    = out_valid & out_ready;

  always_comb begin
    state_n       = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_n = OCC_EMPTY;
    end else begin
      unique case (state)
        OCC_EMPTY: if (accept) begin
          state_n      = OCC_ONE;
          load_out_new = 1'b1;
        end
        OCC_ONE: begin
          if (accept && retire) begin
            load_out_new = 1'b1;
          end else if (accept) begin
            state_n   = OCC_FULL;
            load_skid = 1'b1;
          end else if (retire) begin
            state_n = OCC_EMPTY;
          end
        end
        OCC_FULL: if (retire) begin
          state_n       = OCC_ONE;
          load_out_skid = 1'b1;
        end
        default: state_n = OCC_EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next occupancy so it is exactly "skid empty"
  // in the following cycle without a combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != OCC_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_q  <= '0;
      out_src_q  <= IMM_NONE;
      out_ill_q  <= 1'b0;
      out_pc_q   <= '0;
      skid_imm_q <= '0;
      skid_src_q <= IMM_NONE;
      skid_ill_q <= 1'b0;
      skid_pc_q  <= '0;
    end else begin
      if (load_out_new) begin
        out_imm_q <= dec_imm;
        out_src_q <= dec_src;
        out_ill_q <= dec_ill;
        out_pc_q  <= in_pc;
      end else if (load_out_skid) begin
        out_imm_q <= skid_imm_q;
        out_src_q <= skid_src_q;
        out_ill_q <= skid_ill_q;
        out_pc_q  <= skid_pc_q;
      end
      if (load_skid) begin
        skid_imm_q <= dec_imm;
        skid_src_q <= dec_src;
        skid_ill_q <= dec_ill;
        skid_pc_q  <= in_pc;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_imm     = out_imm_q;
  assign out_imm_src = out_src_q;
  assign out_illegal = out_ill_q;
  assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed RV32 cases, back-pressure, flush, reset, random traffic.
module tb_imm_gen_pipe;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_src;
  logic            out_illegal;
  logic [PC_W-1:0] out_pc;

  imm_gen_pipe #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_imm_src (out_imm_src),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [2:0]      src;
    logic            ill;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: immediate value as a signed integer from the RV32 field layout.
  function automatic exp_t model(input logic [31:0] w, input logic [PC_W-1:0] pc);
    exp_t   e;
    longint v;
    logic [6:0] op;
    op = w[6:0];
    v = 0;
    e.ill = 1'b0;
    e.src = 3'b111;
    if (op == 7'h03 || op == 7'h13 || op == 7'h67) begin
      e.src = 3'b000; v = longint'($signed(w[31:20]));
    end else if (op == 7'h23) begin
      e.src = 3'b001; v = longint'($signed({w[31:25], w[11:7]}));
    end else if (op == 7'h63) begin
      e.src = 3'b010; v = 2 * longint'($signed({w[31], w[7], w[30:25], w[11:8]}));
    end else if (op == 7'h6F) begin
      e.src = 3'b011; v = 2 * longint'($signed({w[31], w[19:12], w[20], w[30:21]}));
    end else if (op == 7'h37 || op == 7'h17) begin
      e.src = 3'b100; v = longint'($signed(w[31:12])) * 4096;
    end else if (op == 7'h33) begin
      e.src = 3'b111;
    end else if (op == 7'h73) begin
`ifdef IMM_GEN_ZICSR_EN
      e.src = 3'b101; v = longint'(w[19:15]);
`else
      e.ill = 1'b1;
`endif
    end else begin
      e.ill = 1'b1;
    end
    e.imm = v[XLEN-1:0];
    e.pc  = pc;
    return e;
  endfunction

  // Monitor: occupancy checks, retire/compare, then accept/push.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("out_valid_occ", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready_occ",  64'(in_ready),  64'(q.size() < 2));
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_pc",      64'(out_pc),      64'(e.pc));
            chk("out_imm",     64'(out_imm),     64'(e.imm));
            chk("out_imm_src", 64'(out_imm_src), 64'(e.src));
            chk("out_illegal", 64'(out_illegal), 64'(e.ill));
          end
        end
        if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [PC_W-1:0] pc);
    int unsigned n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h73, 7'h7F, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir [7];
  initial begin
    dir = '{32'hFFF00093, 32'h123450B7, 32'hFE112E23, 32'hFE000EE3,
            32'h0000007F, 32'h00000073, 32'h00000033};

    // Reset held three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_imm_src",   64'(out_imm_src), 64'd7);
      chk("rst_imm",       64'(out_imm),   64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(2);

    // Directed decode with out_ready high, back-to-back
    out_ready = 1'b1;
    foreach (dir[i]) send(dir[i], 32'h100 + 32'(i) * 4);
    cycles(3);

    // Back-pressure: three instructions, only two fit until out_ready rises
    out_ready = 1'b0;
    fork
      begin
        send(32'h00500113, 32'h200);
        send(32'h000012B7, 32'h204);
        send(32'hFFC00313, 32'h208);
      end
      begin
        cycles(6);
        out_ready = 1'b1;
      end
    join
    cycles(4);

    // Flush with both entries full and a new instruction presented
    out_ready = 1'b0;
    send(32'h00100093, 32'h300);
    send(32'h00200093, 32'h304);
    in_valid = 1'b1;
    in_instr = 32'h00300093;
    in_pc    = 32'h308;
    flush    = 1'b1;
    cycles(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    cycles(2);
    out_ready = 1'b1;
    send(32'h00400093, 32'h30C);
    cycles(3);

    // Random traffic with random back-pressure and occasional flush
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = 32'h1000 + 32'(i);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycles(1);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    cycles(3);

    // Asynchronous reset mid-transfer discards held entries
    out_ready = 1'b0;
    send(32'h00A00093, 32'h400);
    send(32'h00B00093, 32'h404);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid),   64'd0);
    chk("async_rst_in_ready",  64'(in_ready),    64'd1);
    chk("async_rst_imm_src",   64'(out_imm_src), 64'd7);
    chk("async_rst_imm",       64'(out_imm),     64'd0);
    chk("async_rst_illegal",   64'(out_illegal), 64'd0);
    chk("async_rst_pc",        64'(out_pc),      64'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    out_ready = 1'b1;
    send(32'h800000B7, 32'h408);
    cycles(4);

    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
